// File: rtl/ghost_pkg.sv
// Shared types and helpers for the ghost movement controller.
package ghost_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        QUERY = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [1:0] off_t;

    // Relative turn offsets, added to the heading modulo 4.
    localparam off_t OFF_STRAIGHT = 2'd0;
    localparam off_t OFF_RIGHT    = 2'd1;
    localparam off_t OFF_REVERSE  = 2'd2;
    localparam off_t OFF_LEFT     = 2'd3;

    localparam logic [3:0] MOVE_LEFT     = 4'd1;
    localparam logic [3:0] MOVE_STRAIGHT = 4'd2;
    localparam logic [3:0] MOVE_RIGHT    = 4'd3;

    // Random move code to preferred turn; unknown codes go straight.
    function automatic off_t code_offset(input logic [3:0] code);
        case (code)
            MOVE_LEFT:     return OFF_LEFT;
            MOVE_STRAIGHT: return OFF_STRAIGHT;
            MOVE_RIGHT:    return OFF_RIGHT;
            default:       return OFF_STRAIGHT;
        endcase
    endfunction

    // Candidate idx of the fallback list: preferred, rest of {0,1,3}, reverse.
    function automatic off_t cand_offset(input off_t pref, input logic [1:0] idx);
        case (idx)
            2'd0:    return pref;
            2'd1:    return (pref == OFF_STRAIGHT) ? OFF_RIGHT : OFF_STRAIGHT;
            2'd2:    return (pref == OFF_LEFT) ? OFF_RIGHT : OFF_LEFT;
            default: return OFF_REVERSE;
        endcase
    endfunction

    // Apply a relative offset to a heading.
    function automatic dir_t turn(input dir_t d, input off_t off);
        logic [1:0] s;
        s = 2'(d) + off;
        return dir_t'(s);
    endfunction

endpackage

// File: rtl/ghost_next_cell.sv
// Neighbouring cell in a given heading, with maze-bounds check (no wrap).
module ghost_next_cell
    import ghost_pkg::*;
#(
    parameter int unsigned GRID_W = 32,
    parameter int unsigned GRID_H = 24,
    parameter int unsigned X_W    = 5,
    parameter int unsigned Y_W    = 5
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  dir_t           dir,
    output logic [X_W-1:0] nx,
    output logic [Y_W-1:0] ny,
    output logic           in_grid
);

    // Step one cell and flag moves that would leave the maze.
    always_comb begin
        nx      = x;
        ny      = y;
        in_grid = 1'b0;
        case (dir)
            UP: begin
                ny      = y - Y_W'(1);
                in_grid = (y != '0);
            end
            DOWN: begin
                ny      = y + Y_W'(1);
                in_grid = (32'(y) < 32'(GRID_H - 1));
            end
            LEFT: begin
                nx      = x - X_W'(1);
                in_grid = (x != '0);
            end
            default: begin
                nx      = x + X_W'(1);
                in_grid = (32'(x) < 32'(GRID_W - 1));
            end
        endcase
    end

endmodule

// File: rtl/ghost_step_ctrl.sv
// One-cell-per-tick ghost mover: turn choice, wall probing, fallback, commit.
module ghost_step_ctrl
    import ghost_pkg::*;
#(
    parameter int unsigned GRID_W    = 32,
    parameter int unsigned GRID_H    = 24,
    parameter int unsigned X_W       = 5,
    parameter int unsigned Y_W       = 5,
    parameter int unsigned START_X   = 5,
    parameter int unsigned START_Y   = 5,
    parameter int unsigned START_DIR = 0
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_tick,
    input  logic [3:0]     i_random_move,
    output logic           o_query_valid,
    output logic [X_W-1:0] o_query_x,
    output logic [Y_W-1:0] o_query_y,
    input  logic           i_wall,
    input  logic [X_W-1:0] i_pac_x,
    input  logic [Y_W-1:0] i_pac_y,
    output logic [X_W-1:0] o_ghost_x,
    output logic [Y_W-1:0] o_ghost_y,
    output logic [1:0]     o_ghost_dir,
    output logic           o_busy,
    output logic           o_step_done,
    output logic           o_hit
);

    state_t         state, state_n;
    dir_t           dir, dir_n, cand_dir, cand_dir_n;
    logic [X_W-1:0] gx, gx_n, qx_n;
    logic [Y_W-1:0] gy, gy_n, qy_n;
    off_t           pref, pref_n;
    logic [1:0]     attempt, attempt_n;
    logic           cand_ok, cand_ok_n;
    logic           qv_n, done_n, busy_n, hit_n;

    off_t           load_pref;
    logic [1:0]     load_idx;
    dir_t           load_dir;
    logic [X_W-1:0] load_x;
    logic [Y_W-1:0] load_y;
    logic           load_ok;

    // Candidate that would be probed next: first one from IDLE, else the following one.
    always_comb begin
        load_pref = pref;
        load_idx  = 2'(attempt + 2'd1);
        if (state == IDLE) begin
            load_pref = code_offset(i_random_move);
            load_idx  = 2'd0;
        end
        load_dir = turn(dir, cand_offset(load_pref, load_idx));
    end

    ghost_next_cell #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .X_W    (X_W),
        .Y_W    (Y_W)
    ) u_next_cell (
        .x       (gx),
        .y       (gy),
        .dir     (load_dir),
        .nx      (load_x),
        .ny      (load_y),
        .in_grid (load_ok)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_n    = state;
        dir_n      = dir;
        gx_n       = gx;
        gy_n       = gy;
        pref_n     = pref;
        attempt_n  = attempt;
        cand_dir_n = cand_dir;
        cand_ok_n  = cand_ok;
        qv_n       = 1'b0;
        qx_n       = o_query_x;
        qy_n       = o_query_y;
        done_n     = 1'b0;

        case (state)
            IDLE: begin
                if (i_tick) begin
                    state_n    = QUERY;
                    pref_n     = load_pref;
                    attempt_n  = 2'd0;
                    cand_dir_n = load_dir;
                    cand_ok_n  = load_ok;
                    qv_n       = load_ok;
                    qx_n       = load_x;
                    qy_n       = load_y;
                end
            end
            QUERY: begin
                state_n = CHECK;
            end
            CHECK: begin
                if (cand_ok && !i_wall) begin
                    state_n = DONE;
                    gx_n    = o_query_x;
                    gy_n    = o_query_y;
                    dir_n   = cand_dir;
                    done_n  = 1'b1;
                end else if (attempt == 2'd3) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else begin
                    state_n    = QUERY;
                    attempt_n  = 2'(attempt + 2'd1);
                    cand_dir_n = load_dir;
                    cand_ok_n  = load_ok;
                    qv_n       = load_ok;
                    qx_n       = load_x;
                    qy_n       = load_y;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
        hit_n  = (gx == i_pac_x) && (gy == i_pac_y);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            dir           <= dir_t'(2'(START_DIR));
            gx            <= X_W'(START_X);
            gy            <= Y_W'(START_Y);
            pref          <= OFF_STRAIGHT;
            attempt       <= 2'd0;
            cand_dir      <= UP;
            cand_ok       <= 1'b0;
            o_query_valid <= 1'b0;
            o_query_x     <= '0;
            o_query_y     <= '0;
            o_step_done   <= 1'b0;
            o_busy        <= 1'b0;
            o_hit         <= 1'b0;
        end else begin
            state         <= state_n;
            dir           <= dir_n;
            gx            <= gx_n;
            gy            <= gy_n;
            pref          <= pref_n;
            attempt       <= attempt_n;
            cand_dir      <= cand_dir_n;
            cand_ok       <= cand_ok_n;
            o_query_valid <= qv_n;
            o_query_x     <= qx_n;
            o_query_y     <= qy_n;
            o_step_done   <= done_n;
            o_busy        <= busy_n;
            o_hit         <= hit_n;
        end
    end

    assign o_ghost_x   = gx;
    assign o_ghost_y   = gy;
    assign o_ghost_dir = 2'(dir);

endmodule

// File: tb/tb_ghost_step_ctrl.sv
// Directed bench for ghost_step_ctrl with a small wall-map responder.
module tb_ghost_step_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_tick = 1'b0;
    logic [3:0] i_random_move = 4'd0;
    logic       o_query_valid;
    logic [4:0] o_query_x, o_query_y;
    logic       i_wall;
    logic [4:0] i_pac_x = 5'd20, i_pac_y = 5'd20;
    logic [4:0] o_ghost_x, o_ghost_y;
    logic [1:0] o_ghost_dir;
    logic       o_busy, o_step_done, o_hit;

    int tests_run = 0;
    int tests_failed = 0;
    int wall_mode = 0;
    int qx[$];
    int qy[$];
    logic first_valid;
    int lat;

    ghost_step_ctrl dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_tick        (i_tick),
        .i_random_move (i_random_move),
        .o_query_valid (o_query_valid),
        .o_query_x     (o_query_x),
        .o_query_y     (o_query_y),
        .i_wall        (i_wall),
        .i_pac_x       (i_pac_x),
        .i_pac_y       (i_pac_y),
        .o_ghost_x     (o_ghost_x),
        .o_ghost_y     (o_ghost_y),
        .o_ghost_dir   (o_ghost_dir),
        .o_busy        (o_busy),
        .o_step_done   (o_step_done),
        .o_hit         (o_hit)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic wall_at(input logic [4:0] x, input logic [4:0] y);
        case (wall_mode)
            1:       return (x == 5'd4) && (y == 5'd5);
            2:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Wall map with one cycle of read latency.
    always @(posedge i_clk) i_wall <= o_query_valid && wall_at(o_query_x, o_query_y);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    // Issue one tick and log probes until the done pulse (bounded); returns at T+lat.
    task automatic do_step(input logic [3:0] code);
        qx.delete();
        qy.delete();
        lat = -1;
        first_valid = 1'b0;
        @(negedge i_clk);
        i_tick = 1'b1;
        i_random_move = code;
        for (int k = 1; k <= 20; k++) begin
            @(negedge i_clk);
            i_tick = 1'b0;
            if (k == 1) first_valid = o_query_valid;
            if (o_query_valid) begin
                qx.push_back(int'(o_query_x));
                qy.push_back(int'(o_query_y));
            end
            if (o_step_done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_pos(input string tag, input int x, input int y, input int d);
        check({tag, "_x"}, 32'(o_ghost_x), 32'(x));
        check({tag, "_y"}, 32'(o_ghost_y), 32'(y));
        check({tag, "_dir"}, 32'(o_ghost_dir), 32'(d));
    endtask

    initial begin
        int dones;
        logic [3:0] route [7];
        route = '{4'd2, 4'd2, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2};

        // Reset values
        do_reset();
        check_pos("rst", 5, 5, 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_qv", 32'(o_query_valid), 0);
        check("rst_qx", 32'(o_query_x), 0);
        check("rst_qy", 32'(o_query_y), 0);
        check("rst_done", 32'(o_step_done), 0);
        check("rst_hit", 32'(o_hit), 0);

        // Straight, first candidate free
        wall_mode = 0;
        do_step(4'd2);
        check("s1_lat", 32'(lat), 3);
        check("s1_first_qv", 32'(first_valid), 1);
        check("s1_nq", 32'(qx.size()), 1);
        if (qx.size() >= 1) begin
            check("s1_q0x", 32'(qx[0]), 5);
            check("s1_q0y", 32'(qy[0]), 4);
        end
        check_pos("s1", 5, 4, 0);
        check("s1_busy_done", 32'(o_busy), 1);
        @(negedge i_clk);
        check("s1_busy_idle", 32'(o_busy), 0);

        // Left turn blocked by a wall, falls back to straight
        do_reset();
        wall_mode = 1;
        do_step(4'd1);
        check("s2_lat", 32'(lat), 5);
        check("s2_nq", 32'(qx.size()), 2);
        if (qx.size() >= 2) begin
            check("s2_q0x", 32'(qx[0]), 4);
            check("s2_q0y", 32'(qy[0]), 5);
            check("s2_q1x", 32'(qx[1]), 5);
            check("s2_q1y", 32'(qy[1]), 4);
        end
        check_pos("s2", 5, 4, 0);

        // All four candidates blocked
        do_reset();
        wall_mode = 2;
        do_step(4'd3);
        check("s3_lat", 32'(lat), 9);
        check("s3_nq", 32'(qx.size()), 4);
        if (qx.size() >= 4) begin
            check("s3_q0", 32'(qx[0] * 100 + qy[0]), 605);
            check("s3_q1", 32'(qx[1] * 100 + qy[1]), 504);
            check("s3_q2", 32'(qx[2] * 100 + qy[2]), 405);
            check("s3_q3", 32'(qx[3] * 100 + qy[3]), 506);
        end
        check_pos("s3", 5, 5, 0);

        // Walk to the left edge, then step straight into the boundary
        do_reset();
        wall_mode = 0;
        for (int i = 0; i < 7; i++) do_step(route[i]);
        check_pos("walk", 0, 3, 3);
        do_step(4'd2);
        check("edge_first_qv", 32'(first_valid), 0);
        check("edge_lat", 32'(lat), 5);
        check("edge_nq", 32'(qx.size()), 1);
        if (qx.size() >= 1) begin
            check("edge_q0x", 32'(qx[0]), 0);
            check("edge_q0y", 32'(qy[0]), 2);
        end
        check_pos("edge", 0, 2, 0);

        // Tick during CHECK is ignored
        do_reset();
        @(negedge i_clk);
        i_tick = 1'b1;
        i_random_move = 4'd2;
        @(negedge i_clk);
        i_tick = 1'b0;
        @(negedge i_clk);
        i_tick = 1'b1;
        i_random_move = 4'd1;
        @(negedge i_clk);
        i_tick = 1'b0;
        check("ign_done", 32'(o_step_done), 1);
        check_pos("ign", 5, 4, 0);
        @(negedge i_clk);
        @(negedge i_clk);
        check("ign_busy", 32'(o_busy), 0);
        check("ign_qv", 32'(o_query_valid), 0);

        // Reset during CHECK aborts the step
        do_reset();
        @(negedge i_clk);
        i_tick = 1'b1;
        i_random_move = 4'd2;
        @(negedge i_clk);
        i_tick = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        check_pos("abort", 5, 5, 0);
        check("abort_busy", 32'(o_busy), 0);
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            if (o_step_done) dones++;
            @(negedge i_clk);
        end
        check("abort_dones", 32'(dones), 0);
        check_pos("abort_hold", 5, 5, 0);

        // Hit flag lags position by one cycle
        i_pac_x = 5'd5;
        i_pac_y = 5'd5;
        check("hit_before", 32'(o_hit), 0);
        @(negedge i_clk);
        check("hit_after", 32'(o_hit), 1);
        i_pac_y = 5'd4;
        @(negedge i_clk);
        check("hit_moved_pac", 32'(o_hit), 0);
        do_step(4'd2);
        check("hit_lag_pos", 32'(o_ghost_y), 4);
        check("hit_lag", 32'(o_hit), 0);
        @(negedge i_clk);
        check("hit_lag_next", 32'(o_hit), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
